// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: Moore FSM driving the datapath strobes,
// with a memory-wait timeout, an illegal-opcode trap and a retired-instruction count.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT     = 15,
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic [5:0]       funct_op_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             iord_o,
  output logic             reg_write_o,
  output logic             branch_o,
  output logic [1:0]       reg_dst_o,
  output logic [1:0]       mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [2:0]       branch_type_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] instr_count_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC     = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_IMM_EXEC = 4'd10;
  localparam logic [3:0] S_IMM_WB   = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  localparam int WAIT_W =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM =
    WAIT_W'(MEM_TIMEOUT - 1);

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic is_rtype;
  logic is_nop;
  logic is_jr;
  logic is_rop;
  logic is_branch;
  logic is_imm;
  logic is_mem;
  logic is_jump;
  logic is_jal;
  logic is_illegal;
  logic mem_wait;
  logic timeout;
  logic retire;

  always_comb begin
    is_rtype   = (instr_op_i == 6'h00);
    is_nop     = is_rtype && (funct_op_i == 6'h00);
    is_jr      = is_rtype && (funct_op_i == 6'h08);
    is_rop     = is_rtype && !is_nop && !is_jr;
    is_branch  = instr_op_i inside {6'h04, 6'h05, 6'h06, 6'h01};
    is_imm     = instr_op_i inside {6'h08, 6'h0B, 6'h0D, 6'h0F};
    is_mem     = instr_op_i inside {6'h23, 6'h2B};
    is_jump    = instr_op_i inside {6'h02, 6'h03};
    is_jal     = (instr_op_i == 6'h03);
    is_illegal = !(is_rtype || is_branch || is_imm
                   || is_mem || is_jump);
  end

  // A wait cycle is one spent in a memory state without mem_ready_i;
  // a ready on the limit cycle is not a wait, so it advances normally.
  always_comb begin
    mem_wait = !mem_ready_i &&
               ((state_q == S_FETCH) ||
                (state_q == S_MEM_RD) ||
                (state_q == S_MEM_WR));
    timeout  = mem_wait && (wait_q == WAIT_LIM);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_nop:     state_d = S_FETCH;
          is_jr:      state_d = S_JUMP;
          is_rop:     state_d = S_EXEC;
          is_branch:  state_d = S_BRANCH;
          is_imm:     state_d = S_IMM_EXEC;
          is_mem:     state_d = S_MEM_ADDR;
          is_jump:    state_d = S_JUMP;
          is_illegal: state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        state_d = (instr_op_i == 6'h23) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_EXEC:     state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_IMM_EXEC: state_d = S_IMM_WB;
      S_IMM_WB:   state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
    if (timeout) state_d = S_HALT;
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_DECODE: retire = is_nop;
      S_MEM_WR: retire = mem_ready_i;
      S_MEM_WB,
      S_R_WB,
      S_IMM_WB,
      S_BRANCH,
      S_JUMP:   retire = 1'b1;
      default:  retire = 1'b0;
    endcase
  end

  always_comb begin
    if (state_d != state_q) wait_d = '0;
    else if (mem_wait)      wait_d = wait_q + WAIT_W'(1);
    else                    wait_d = wait_q;
    fault_d = fault_q | timeout;
    cnt_d   = cnt_q + CNT_W'(retire);
  end

  always_comb begin
    pc_write_o    = 1'b0;
    ir_write_o    = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    iord_o        = 1'b0;
    reg_write_o   = 1'b0;
    branch_o      = 1'b0;
    reg_dst_o     = 2'b00;
    mem_to_reg_o  = 2'b00;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'b00;
    alu_op_o      = 3'b000;
    pc_source_o   = 2'b00;
    branch_type_o = 3'b000;
    illegal_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        illegal_o   = is_illegal;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 2'b01;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b010;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 2'b01;
      end
      S_IMM_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (instr_op_i)
          6'h0B:   alu_op_o = 3'b111;
          6'h0D:   alu_op_o = 3'b110;
          default: alu_op_o = 3'b101;
        endcase
      end
      S_IMM_WB: begin
        reg_write_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b001;
        branch_o    = 1'b1;
        pc_source_o = 2'b01;
        case (instr_op_i)
          6'h05:   branch_type_o = 3'b010;
          6'h06:   branch_type_o = 3'b001;
          6'h01:   branch_type_o = 3'b011;
          default: branch_type_o = 3'b000;
        endcase
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 2'b10;
          mem_to_reg_o = 2'b11;
        end
      end
      default: ;
    endcase
  end

  assign state_o       = state_q;
  assign fault_o       = fault_q;
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction table plus
// hand-written wait, timeout, illegal, wrap and reset sequences.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy;
  logic [5:0]  op, fn;
  logic        pcw, irw, mrd, mwr, iord, rw, br;
  logic [1:0]  rdst, m2r, asb, psrc;
  logic        asa, ill, flt;
  logic [2:0]  aop, bt;
  logic [3:0]  st;
  logic [31:0] cnt;

  logic        rst2, rdy2;
  logic [5:0]  op2, fn2;
  logic        pcw2, irw2, mrd2, mwr2, iord2, rw2, br2;
  logic [1:0]  rdst2, m2r2, asb2, psrc2;
  logic        asa2, ill2, flt2;
  logic [2:0]  aop2, bt2;
  logic [3:0]  st2;
  logic [3:0]  cnt2;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .instr_op_i(op), .funct_op_i(fn),
    .mem_ready_i(rdy),
    .pc_write_o(pcw), .ir_write_o(irw),
    .mem_read_o(mrd), .mem_write_o(mwr),
    .iord_o(iord), .reg_write_o(rw),
    .branch_o(br), .reg_dst_o(rdst),
    .mem_to_reg_o(m2r), .alu_src_a_o(asa),
    .alu_src_b_o(asb), .alu_op_o(aop),
    .pc_source_o(psrc), .branch_type_o(bt),
    .state_o(st), .illegal_o(ill),
    .fault_o(flt), .instr_count_o(cnt)
  );

  multicycle_ctrl #(
    .MEM_TIMEOUT(15), .HALT_ON_ILLEGAL(1'b0), .CNT_W(4)
  ) dut2 (
    .clk_i(clk), .rst_i(rst2),
    .instr_op_i(op2), .funct_op_i(fn2),
    .mem_ready_i(rdy2),
    .pc_write_o(pcw2), .ir_write_o(irw2),
    .mem_read_o(mrd2), .mem_write_o(mwr2),
    .iord_o(iord2), .reg_write_o(rw2),
    .branch_o(br2), .reg_dst_o(rdst2),
    .mem_to_reg_o(m2r2), .alu_src_a_o(asa2),
    .alu_src_b_o(asb2), .alu_op_o(aop2),
    .pc_source_o(psrc2), .branch_type_o(bt2),
    .state_o(st2), .illegal_o(ill2),
    .fault_o(flt2), .instr_count_o(cnt2)
  );

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    int          len;
    logic [23:0] path;
    int          idx;
    logic [2:0]  aop;
    logic [2:0]  bt;
    logic [1:0]  psrc;
    logic        rw;
  } vec_t;

  vec_t tbl [15];
  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset1();
    rst = 1'b1;
    rdy = 1'b0;
    op  = 6'h00;
    fn  = 6'h00;
    step();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    logic rw_seen;
    v = tbl[k];
    rw_seen = 1'b0;
    op  = v.op;
    fn  = v.fn;
    rdy = 1'b1;
    for (int i = 0; i < v.len; i++) begin
      #1;
      chk($sformatf("vec%0d op%02h st%0d", k, v.op, i),
          32'(st), 32'(v.path[i*4 +: 4]));
      if (i == v.idx) begin
        chk($sformatf("vec%0d alu_op", k), 32'(aop), 32'(v.aop));
        chk($sformatf("vec%0d br_type", k), 32'(bt), 32'(v.bt));
        chk($sformatf("vec%0d pc_src", k), 32'(psrc), 32'(v.psrc));
      end
      rw_seen |= rw;
      step();
    end
    #1;
    exp_cnt++;
    chk($sformatf("vec%0d end st", k), 32'(st), 32'd0);
    chk($sformatf("vec%0d reg_wr", k), 32'(rw_seen), 32'(v.rw));
    chk($sformatf("vec%0d count", k), cnt, 32'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    rst = 1'b1; rdy = 1'b0; op = 6'h00; fn = 6'h00;
    rst2 = 1'b1; rdy2 = 1'b0; op2 = 6'h00; fn2 = 6'h00;

    tbl[0]  = '{6'h23, 6'h00, 5, 24'h43210, 2, 3'b000, 3'b000, 2'b00, 1'b1};
    tbl[1]  = '{6'h2B, 6'h00, 4, 24'h05210, 2, 3'b000, 3'b000, 2'b00, 1'b0};
    tbl[2]  = '{6'h00, 6'h20, 4, 24'h07610, 2, 3'b010, 3'b000, 2'b00, 1'b1};
    tbl[3]  = '{6'h00, 6'h00, 2, 24'h00010, 1, 3'b000, 3'b000, 2'b00, 1'b0};
    tbl[4]  = '{6'h00, 6'h08, 3, 24'h00910, 2, 3'b000, 3'b000, 2'b11, 1'b0};
    tbl[5]  = '{6'h02, 6'h00, 3, 24'h00910, 2, 3'b000, 3'b000, 2'b10, 1'b0};
    tbl[6]  = '{6'h03, 6'h00, 3, 24'h00910, 2, 3'b000, 3'b000, 2'b10, 1'b1};
    tbl[7]  = '{6'h04, 6'h00, 3, 24'h00810, 2, 3'b001, 3'b000, 2'b01, 1'b0};
    tbl[8]  = '{6'h05, 6'h00, 3, 24'h00810, 2, 3'b001, 3'b010, 2'b01, 1'b0};
    tbl[9]  = '{6'h06, 6'h00, 3, 24'h00810, 2, 3'b001, 3'b001, 2'b01, 1'b0};
    tbl[10] = '{6'h01, 6'h00, 3, 24'h00810, 2, 3'b001, 3'b011, 2'b01, 1'b0};
    tbl[11] = '{6'h08, 6'h00, 4, 24'h0BA10, 2, 3'b101, 3'b000, 2'b00, 1'b1};
    tbl[12] = '{6'h0B, 6'h00, 4, 24'h0BA10, 2, 3'b111, 3'b000, 2'b00, 1'b1};
    tbl[13] = '{6'h0D, 6'h00, 4, 24'h0BA10, 2, 3'b110, 3'b000, 2'b00, 1'b1};
    tbl[14] = '{6'h0F, 6'h00, 4, 24'h0BA10, 2, 3'b101, 3'b000, 2'b00, 1'b1};

    #3;
    chk("rst state", 32'(st), 32'd0);
    chk("rst count", cnt, 32'd0);
    chk("rst fault", 32'(flt), 32'd0);
    chk("rst illegal", 32'(ill), 32'd0);

    reset1();
    for (int k = 0; k < 15; k++) run_vec(k);

    // FETCH gating and lw write-back
    reset1();
    op = 6'h23;
    #1;
    chk("fetch wait ir_wr", 32'(irw), 32'd0);
    chk("fetch wait pc_wr", 32'(pcw), 32'd0);
    chk("fetch mem_rd", 32'(mrd), 32'd1);
    step();
    rdy = 1'b1;
    #1;
    chk("fetch rdy ir_wr", 32'(irw), 32'd1);
    chk("fetch rdy pc_wr", 32'(pcw), 32'd1);
    step(); #1;
    chk("decode alu_src_b", 32'(asb), 32'd3);
    step(); step(); #1;
    chk("memrd iord", 32'(iord), 32'd1);
    step(); #1;
    chk("memwb reg_wr", 32'(rw), 32'd1);
    chk("memwb m2r", 32'(m2r), 32'd1);
    chk("memwb dst", 32'(rdst), 32'd0);
    step(); #1;
    chk("lw count", cnt, 32'd1);

    // sw stalled three cycles in MEM_WR
    reset1();
    op = 6'h2B; rdy = 1'b1;
    step(); step(); step();
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      rdy = (k == 3);
      #1;
      if (st !== 4'd5 || mwr !== 1'b1 || rw !== 1'b0) bad++;
      step();
    end
    chk("sw wait held", bad, 0);
    #1;
    chk("sw end st", 32'(st), 32'd0);
    chk("sw count", cnt, 32'd1);

    // jal then jr in JUMP
    reset1();
    op = 6'h03; rdy = 1'b1;
    step(); step(); #1;
    chk("jal st", 32'(st), 32'd9);
    chk("jal pc_wr", 32'(pcw), 32'd1);
    chk("jal pc_src", 32'(psrc), 32'd2);
    chk("jal dst", 32'(rdst), 32'd2);
    chk("jal m2r", 32'(m2r), 32'd3);
    chk("jal reg_wr", 32'(rw), 32'd1);
    step();
    op = 6'h00; fn = 6'h08;
    step(); step(); #1;
    chk("jr pc_src", 32'(psrc), 32'd3);
    chk("jr reg_wr", 32'(rw), 32'd0);
    chk("jr pc_wr", 32'(pcw), 32'd1);
    step();

    // illegal opcode halts
    reset1();
    op = 6'h3F; rdy = 1'b1;
    step(); #1;
    chk("ill pulse", 32'(ill), 32'd1);
    step(); #1;
    chk("ill halt st", 32'(st), 32'd12);
    chk("ill pulse end", 32'(ill), 32'd0);
    chk("halt mem_rd", 32'(mrd), 32'd0);
    repeat (3) step();
    #1;
    chk("halt held", 32'(st), 32'd12);
    chk("ill count", cnt, 32'd0);

    // FETCH timeout
    reset1();
    op = 6'h23; rdy = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (st !== 4'd0 || flt !== 1'b0) bad++;
      step();
    end
    chk("timeout fetch held", bad, 0);
    #1;
    chk("timeout st", 32'(st), 32'd12);
    chk("timeout fault", 32'(flt), 32'd1);
    rdy = 1'b1;
    repeat (3) step();
    #1;
    chk("timeout sticky st", 32'(st), 32'd12);
    chk("timeout sticky flt", 32'(flt), 32'd1);

    // ready on the limit cycle wins
    reset1();
    #1;
    chk("fault cleared", 32'(flt), 32'd0);
    repeat (14) step();
    rdy = 1'b1;
    step(); #1;
    chk("limit ready st", 32'(st), 32'd1);
    chk("limit ready flt", 32'(flt), 32'd0);

    // async reset mid MEM_RD
    reset1();
    op = 6'h23; rdy = 1'b1;
    repeat (5) step();
    repeat (3) step();
    rdy = 1'b0;
    #1;
    chk("pre rst st", 32'(st), 32'd3);
    chk("pre rst cnt", cnt, 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("async rst st", 32'(st), 32'd0);
    chk("async rst cnt", cnt, 32'd0);
    step();
    rst = 1'b0; rdy = 1'b1;
    step(); #1;
    chk("post rst st", 32'(st), 32'd1);
    rst = 1'b1;

    // dut2: illegal as nop, then counter wrap
    step();
    rst2 = 1'b0;
    op2 = 6'h3F; rdy2 = 1'b1;
    step(); #1;
    chk("d2 ill pulse", 32'(ill2), 32'd1);
    step(); #1;
    chk("d2 ill fetch", 32'(st2), 32'd0);
    chk("d2 ill count", 32'(cnt2), 32'd0);
    op2 = 6'h00; fn2 = 6'h00;
    for (int n = 1; n <= 16; n++) begin
      step(); step();
      if (n == 15) begin
        #1;
        chk("d2 count 15", 32'(cnt2), 32'd15);
      end
    end
    #1;
    chk("d2 wrap", 32'(cnt2), 32'd0);
    chk("d2 st", 32'(st2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max consecutive memory-wait cycles before fault.
REQ-002 Parameter HALT_ON_ILLEGAL, default 1: 1 = illegal opcode halts; 0 = treated as nop.
REQ-003 Parameter CNT_W, default 32: retired-instruction counter width.
REQ-004 clk_i  in  1  the single clock, rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 instr_op_i  in  6  opcode from IR; funct_op_i  in  6  funct from IR.
REQ-007 mem_ready_i  in  1  memory access completes this cycle.
REQ-008 pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o, reg_write_o, branch_o  out  1 each  datapath strobes.
REQ-009 reg_dst_o 2, mem_to_reg_o 2, alu_src_a_o 1, alu_src_b_o 2, alu_op_o 3, pc_source_o 2, branch_type_o 3  out  datapath selects.
REQ-010 state_o  out  4  current state; illegal_o  out  1  one-cycle illegal-opcode pulse; fault_o  out  1  sticky timeout flag; instr_count_o  out  CNT_W  retired count.

Function
REQ-011 States (state_o): FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11, HALT=12; codes 13-15 SHALL go to HALT.
REQ-012 Outputs SHALL be Moore functions of state, except ir_write_o/pc_write_o in FETCH, gated by mem_ready_i; unlisted outputs are 0.
REQ-013 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00; ir_write=pc_write=mem_ready_i; stays until mem_ready_i=1, then DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000; next: op 0 funct 0 -> FETCH (nop); op 0 funct 8 -> JUMP (jr); op 0 other -> EXEC; 04/05/06/01 -> BRANCH; 08/0B/0D/0F -> IMM_EXEC; 23/2B -> MEM_ADDR; 02/03 -> JUMP; any other -> illegal.
REQ-015 EXEC: alu_src_a=1, alu_src_b=00, alu_op=010 -> R_WB; R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
REQ-016 IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op 101 (08, 0F), 111 (0B), 110 (0D) -> IMM_WB; IMM_WB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000 -> MEM_RD (23) or MEM_WR (2B).
REQ-018 MEM_RD: mem_read=1, iord=1; waits for mem_ready_i -> MEM_WB; MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
REQ-019 MEM_WR: mem_write=1, iord=1; waits for mem_ready_i -> FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, branch=1, pc_source=01, branch_type 000 (04), 010 (05), 001 (06), 011 (01) -> FETCH.
REQ-021 JUMP: pc_write=1; pc_source=11 for jr, 10 for j/jal; jal adds reg_write=1, reg_dst=10, mem_to_reg=11 -> FETCH; opcode/funct are sampled from IR, stable after DECODE.
REQ-022 Wait counter: counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready_i=0, clears on state change; reaching MEM_TIMEOUT -> HALT and fault_o=1; mem_ready_i=1 on the limit cycle SHALL win (normal advance).
REQ-023 Illegal opcode in DECODE: illegal_o=1 for that cycle; next HALT if HALT_ON_ILLEGAL=1, else FETCH without counting.
REQ-024 HALT: all strobes 0; held until reset.
REQ-025 instr_count_o SHALL increment by 1 on each retiring transition into FETCH (R_WB, IMM_WB, MEM_WB, MEM_WR-complete, BRANCH, JUMP, DECODE-nop), wrapping modulo 2^CNT_W.

Reset
REQ-026 rst_i=1 SHALL immediately force state FETCH, wait counter 0, fault_o 0, instr_count_o 0, illegal_o 0, mid-access included; FETCH strobes resume on the first clk_i edge after rst_i falls.

Verification
REQ-027 lw (op 23), mem_ready_i=1 always -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=01 in MEM_WB; instr_count_o=1.
REQ-028 sw with mem_ready_i low 3 cycles in MEM_WR -> state 5 held 4 cycles, mem_write=1 throughout, then FETCH; no reg_write ever.
REQ-029 jal (op 03) -> JUMP: pc_write=1, pc_source=10, reg_dst=10, mem_to_reg=11; jr (op 0, funct 8) -> pc_source=11, reg_write=0.
REQ-030 mem_ready_i held 0 in FETCH, MEM_TIMEOUT=15 -> HALT (12) after 15 wait cycles, fault_o=1, stays until rst_i.
REQ-031 op 3F, HALT_ON_ILLEGAL=1 -> illegal_o pulse, state 12; with 0 -> back to FETCH, count unchanged.
REQ-032 CNT_W=4, 16 retired nops -> instr_count_o wraps 15 -> 0; rst_i asserted in MEM_RD -> state 0, count 0 asynchronously.
